// File: rtl/cve2_timer.sv
// cve2_timer: memory-mapped RISC-V machine timer (mtime / mtimecmp) for the
// cve2 core's data bus.
//
// Parameters:
//   BaseAddr    - 32-byte-aligned base address of the register window
// Ports:
//   clk_i       - clock, all state updates on the rising edge
//   rst_ni      - asynchronous active-low reset
//   req_i       - bus request from the LSU
//   gnt_o       - bus grant (combinationally equal to req_i)
//   addr_i      - byte address of the request
//   we_i        - 1 = write, 0 = read
//   be_i        - byte enables for writes
//   wdata_i     - write data
//   rvalid_o    - response valid, one cycle after each accepted request
//   rdata_o     - read data (0 for writes and errors)
//   err_o       - response error (bad offset, misaligned or outside window)
//   irq_timer_o - machine timer interrupt, registered (mtime >= mtimecmp)
//
// Register map (offset from BaseAddr):
//   0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI,
//   0x10 CTRL (bit 0 enable, bits 15:8 prescale)
module cve2_timer #(
    parameter logic [31:0] BaseAddr = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        irq_timer_o
);

    typedef enum logic [2:0] {
        RegMtimeLo    = 3'd0,
        RegMtimeHi    = 3'd1,
        RegMtimecmpLo = 3'd2,
        RegMtimecmpHi = 3'd3,
        RegCtrl       = 3'd4
    } reg_sel_e;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        enable_q, enable_d;
    logic [7:0]  prescale_q, prescale_d;
    logic [7:0]  pre_cnt_q, pre_cnt_d;

    logic        addr_ok;
    logic        wr_en;
    logic        tick;
    reg_sel_e    sel;
    logic [31:0] rd_val;
    logic [31:0] rdata_d;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    assign gnt_o = req_i;

    assign sel     = reg_sel_e'(addr_i[4:2]);
    assign addr_ok = (addr_i[31:5] == BaseAddr[31:5]) && (addr_i[1:0] == 2'b00) &&
                     (addr_i[4:2] <= 3'd4);
    // A write with no byte enables is a completed no-op, not a register write.
    assign wr_en   = req_i && we_i && addr_ok && (be_i != '0);
    assign tick    = enable_q && (pre_cnt_q == prescale_q);

    always_comb begin
        rd_val = '0;
        unique case (sel)
            RegMtimeLo:    rd_val = mtime_q[31:0];
            RegMtimeHi:    rd_val = mtime_q[63:32];
            RegMtimecmpLo: rd_val = mtimecmp_q[31:0];
            RegMtimecmpHi: rd_val = mtimecmp_q[63:32];
            RegCtrl:       rd_val = {16'h0000, prescale_q, 7'b000_0000, enable_q};
            default:       rd_val = '0;
        endcase
    end

    assign rdata_d = (req_i && !we_i && addr_ok) ? rd_val : '0;

    always_comb begin
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        enable_d   = enable_q;
        prescale_d = prescale_q;
        pre_cnt_d  = pre_cnt_q;
        if (enable_q) pre_cnt_d = tick ? 8'd0 : pre_cnt_q + 8'd1;

        // A write to either mtime half overrides the increment for all 64 bits.
        if (wr_en) begin
            unique case (sel)
                RegMtimeLo:    mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wdata_i, be_i)};
                RegMtimeHi:    mtime_d = {merge_bytes(mtime_q[63:32], wdata_i, be_i), mtime_q[31:0]};
                RegMtimecmpLo: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wdata_i, be_i);
                RegMtimecmpHi: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdata_i, be_i);
                RegCtrl: begin
                    if (be_i[0]) enable_d = wdata_i[0];
                    if (be_i[1]) prescale_d = wdata_i[15:8];
                    pre_cnt_d = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            enable_q    <= 1'b0;
            prescale_q  <= '0;
            pre_cnt_q   <= '0;
            rvalid_o    <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= '0;
            irq_timer_o <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            enable_q    <= enable_d;
            prescale_q  <= prescale_d;
            pre_cnt_q   <= pre_cnt_d;
            rvalid_o    <= req_i;
            err_o       <= req_i && !addr_ok;
            rdata_o     <= rdata_d;
            irq_timer_o <= (mtime_q >= mtimecmp_q);
        end
    end

endmodule
